// File: rtl/corr_pkg.sv
// Shared defaults and FSM state encoding for the MAC integration controller.
package corr_pkg;

   localparam int unsigned DIM_IN_DEF  = 16;
   localparam int unsigned DIM_ADD_DEF = 64;
   localparam int unsigned CNT_W_DEF   = 24;
   localparam int unsigned MAC_LAT_DEF = 3;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      FLUSH   = 2'd1,
      CAPTURE = 2'd2
   } state_e;

endpackage

// File: rtl/corr_out_reg.sv
// Result holding register with valid/ready handshake and sticky overflow flag.
// MAC_INTEG_FRAME_EN adds a 32-bit frame index loaded alongside each result.
module corr_out_reg
   import corr_pkg::*;
#(
   parameter int unsigned DIM_ADD = DIM_ADD_DEF
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               cap_valid,
   input  logic [DIM_ADD-1:0] cap_data,
   input  logic               m_ready,
   output logic               m_valid,
   output logic [DIM_ADD-1:0] m_data,
   output logic               ovf
`ifdef MAC_INTEG_FRAME_EN
   ,output logic [31:0]       m_frame
`endif
);

   logic               m_valid_q, m_valid_d;
   logic [DIM_ADD-1:0] m_data_q,  m_data_d;
   logic               ovf_q,     ovf_d;
   logic               load;

`ifdef MAC_INTEG_FRAME_EN
   logic [31:0] frame_cnt_q, frame_cnt_d;
   logic [31:0] m_frame_q,   m_frame_d;
`endif

   // A result may only replace the held one if the slot is empty or being drained this cycle.
   always_comb begin
      load      = cap_valid && (!m_valid_q || m_ready);
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      ovf_d     = ovf_q;
      if (cap_valid) begin
         if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = cap_data;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (m_valid_q && m_ready) begin
         m_valid_d = 1'b0;
      end
`ifdef MAC_INTEG_FRAME_EN
      frame_cnt_d = cap_valid ? frame_cnt_q + 32'd1 : frame_cnt_q;
      m_frame_d   = load ? frame_cnt_q : m_frame_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         ovf_q     <= 1'b0;
`ifdef MAC_INTEG_FRAME_EN
         frame_cnt_q <= '0;
         m_frame_q   <= '0;
`endif
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         ovf_q     <= ovf_d;
`ifdef MAC_INTEG_FRAME_EN
         frame_cnt_q <= frame_cnt_d;
         m_frame_q   <= m_frame_d;
`endif
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign ovf     = ovf_q;
`ifdef MAC_INTEG_FRAME_EN
   assign m_frame = m_frame_q;
`endif

endmodule

// File: rtl/mac_integ_ctrl.sv
// Integration controller sequencing an external MAC: accumulate n_int samples, flush, capture.
// MAC_INTEG_FRAME_EN adds the m_frame output (per-capture index).
module mac_integ_ctrl
   import corr_pkg::*;
#(
   parameter int unsigned DIM_IN  = DIM_IN_DEF,
   parameter int unsigned DIM_ADD = DIM_ADD_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned MAC_LAT = MAC_LAT_DEF
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [CNT_W-1:0]   n_int,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DIM_IN-1:0]  s_a,
   input  logic [DIM_IN-1:0]  s_b,
   output logic               mac_en,
   output logic               mac_clr,
   output logic [DIM_IN-1:0]  mac_a,
   output logic [DIM_IN-1:0]  mac_b,
   input  logic [DIM_ADD-1:0] mac_out,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [DIM_ADD-1:0] m_data,
   output logic               ovf
`ifdef MAC_INTEG_FRAME_EN
   ,output logic [31:0]       m_frame
`endif
);

   localparam int unsigned FL_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(MAC_LAT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [CNT_W-1:0] n_lat_q, n_lat_d;
   logic [FL_W-1:0]  flush_q, flush_d;
   logic [CNT_W-1:0] n_eff, n_cur;
   logic             cap_valid;

   // n_int is only honoured at the start of an integration; later samples use the latched copy.
   always_comb begin
      n_eff     = (n_int == '0) ? CNT_W'(1) : n_int;
      n_cur     = (cnt_q == '0) ? n_eff : n_lat_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      n_lat_d   = n_lat_q;
      flush_d   = flush_q;
      s_ready   = 1'b0;
      mac_en    = 1'b0;
      mac_clr   = 1'b0;
      mac_a     = '0;
      mac_b     = '0;
      cap_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            s_ready = 1'b1;
            mac_en  = s_valid;
            mac_a   = s_a;
            mac_b   = s_b;
            if (cnt_q == '0) n_lat_d = n_eff;
            if (s_valid) begin
               if (cnt_q + CNT_W'(1) == n_cur) begin
                  cnt_d   = '0;
                  flush_d = '0;
                  state_d = FLUSH;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         FLUSH: begin
            mac_en = 1'b1;
            if (flush_q == FL_LAST) state_d = CAPTURE;
            else                    flush_d = flush_q + FL_W'(1);
         end
         CAPTURE: begin
            mac_clr   = 1'b1;
            cap_valid = 1'b1;
            state_d   = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
      if (clr) mac_clr = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         n_lat_q <= CNT_W'(1);
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_lat_q <= n_lat_d;
         flush_q <= flush_d;
      end
   end

   corr_out_reg #(
      .DIM_ADD (DIM_ADD)
   ) u_out_reg (
      .clk       (clk),
      .clr       (clr),
      .cap_valid (cap_valid),
      .cap_data  (mac_out),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .ovf       (ovf)
`ifdef MAC_INTEG_FRAME_EN
      ,.m_frame  (m_frame)
`endif
   );

endmodule

// File: tb/tb_mac_integ_ctrl.sv
// Scoreboard bench for mac_integ_ctrl with a behavioural pipelined saturating MAC model.
module tb_mac_integ_ctrl;

   localparam int unsigned DIM_IN  = 16;
   localparam int unsigned DIM_ADD = 64;
   localparam int unsigned CNT_W   = 24;
   localparam int unsigned MAC_LAT = 3;

   logic               clk = 1'b0;
   logic               clr = 1'b1;
   logic [CNT_W-1:0]   n_int = '0;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic [DIM_IN-1:0]  s_a = '0, s_b = '0;
   logic               mac_en, mac_clr;
   logic [DIM_IN-1:0]  mac_a, mac_b;
   logic [DIM_ADD-1:0] mac_out;
   logic               m_valid;
   logic               m_ready = 1'b1;
   logic [DIM_ADD-1:0] m_data;
   logic               ovf;
`ifdef MAC_INTEG_FRAME_EN
   logic [31:0]        m_frame;
`endif

   int checks = 0;
   int errors = 0;
   logic [DIM_ADD-1:0] exp_q[$];

   always #5 clk = ~clk;

   mac_integ_ctrl #(
      .DIM_IN  (DIM_IN),
      .DIM_ADD (DIM_ADD),
      .CNT_W   (CNT_W),
      .MAC_LAT (MAC_LAT)
   ) dut (
      .clk     (clk),
      .clr     (clr),
      .n_int   (n_int),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_a     (s_a),
      .s_b     (s_b),
      .mac_en  (mac_en),
      .mac_clr (mac_clr),
      .mac_a   (mac_a),
      .mac_b   (mac_b),
      .mac_out (mac_out),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .ovf     (ovf)
`ifdef MAC_INTEG_FRAME_EN
      ,.m_frame (m_frame)
`endif
   );

   // Accumulator stand-in: saturating Q15-style product, MAC_LAT-1 stage pipeline, then add.
   function automatic logic [DIM_ADD-1:0] sat_mul(input logic signed [15:0] a, input logic signed [15:0] b);
      logic signed [31:0] p;
      p = a * b;
      if (p == 32'sh4000_0000) p = 32'sh3FFF_FFFF;
      return {{32{p[31]}}, p};
   endfunction

   logic [DIM_ADD-1:0] pipe [MAC_LAT-1];
   logic [DIM_ADD-1:0] acc;
   assign mac_out = acc;

   always @(posedge clk) begin
      if (mac_clr) begin
         acc <= '0;
         for (int i = 0; i < MAC_LAT - 1; i++) pipe[i] <= '0;
      end else if (mac_en) begin
         pipe[0] <= sat_mul(mac_a, mac_b);
         for (int i = 1; i < MAC_LAT - 1; i++) pipe[i] <= pipe[i-1];
         acc <= acc + pipe[MAC_LAT-2];
      end
   end

   // Monitor: every handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (!clr && m_valid && m_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected: got %h required none", m_data);
         end else begin
            logic [DIM_ADD-1:0] e;
            e = exp_q.pop_front();
            if (m_data !== e) begin
               errors++;
               $display("FAIL result_data: got %h required %h", m_data, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [DIM_ADD-1:0] act, input logic [DIM_ADD-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
      int waited = 0;
      s_valid = 1'b1;
      s_a = a;
      s_b = b;
      while (!s_ready && waited < 100) begin
         tick(1);
         waited++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got s_ready=0 required 1");
      end
      tick(1);
      s_valid = 1'b0;
   endtask

   task automatic drain;
      int waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         tick(1);
         waited++;
      end
      check("drain_queue", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_clr;
      clr = 1'b1;
      tick(1);
      check("mac_clr_in_clr", 64'(mac_clr), 64'd1);
      tick(1);
      clr = 1'b0;
   endtask

   initial begin : stim
      int lo;
      tick(2);
      check("mac_clr_reset", 64'(mac_clr), 64'd1);
      clr = 1'b0;
      check("m_valid_reset", 64'(m_valid), 64'd0);
      check("m_data_reset",  m_data,        64'd0);
      check("ovf_reset",     64'(ovf),     64'd0);
      check("s_ready_reset", 64'(s_ready), 64'd1);
      check("mac_en_idle",   64'(mac_en),  64'd0);

      // Four samples of 2*2.
      n_int = 24'd4;
      exp_q.push_back(64'd16);
      repeat (4) send(16'sd2, 16'sd2);
      drain();

      // Saturated square: 2 * 0x3FFFFFFF.
      n_int = 24'd2;
      exp_q.push_back(64'h0000_0000_7FFF_FFFE);
      repeat (2) send(-16'sd32768, -16'sd32768);
      drain();

      // n_int=0 behaves as 1: one result per sample.
      n_int = 24'd0;
      exp_q.push_back(-64'sd15);
      exp_q.push_back(64'd20);
      send(16'sd3, -16'sd5);
      send(16'sd4, 16'sd5);
      drain();
      check("ovf_after_flow", 64'(ovf), 64'd0);

      // Backpressure: first result held, later ones dropped.
      n_int = 24'd1;
      m_ready = 1'b0;
      exp_q.push_back(64'd1);
      send(16'sd1, 16'sd1);
      send(16'sd2, 16'sd2);
      send(16'sd3, 16'sd3);
      tick(MAC_LAT + 4);
      check("stall_m_valid", 64'(m_valid), 64'd1);
      check("stall_m_data",  m_data,        64'd1);
      check("stall_ovf",     64'(ovf),     64'd1);
      m_ready = 1'b1;
      tick(1);
      check("post_hs_m_valid", 64'(m_valid), 64'd0);
      check("ovf_sticky",      64'(ovf),     64'd1);
      tick(3);
      check("no_extra_result", 64'(m_valid), 64'd0);
      do_clr();
      check("ovf_cleared", 64'(ovf), 64'd0);

      // Abort in the second FLUSH cycle: nothing emitted, no residue.
      n_int = 24'd3;
      repeat (3) send(16'sd5, 16'sd5);
      tick(1);
      do_clr();
      tick(MAC_LAT + 4);
      check("abort_no_valid", 64'(m_valid), 64'd0);
      exp_q.push_back(64'd3);
      repeat (3) send(16'sd1, 16'sd1);
      drain();

      // 50% duty input, s_ready low window per integration.
      n_int = 24'd8;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(64'd56);
         for (int j = 0; j < 8; j++) begin
            send(16'sd1, 16'sd7);
            if (j != 7) tick(1);
         end
         lo = 0;
         while (!s_ready && lo < 50) begin
            lo++;
            tick(1);
         end
         check("s_ready_low_cycles", 64'(lo), 64'(MAC_LAT + 1));
      end
      drain();
      check("final_ovf", 64'(ovf), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mac_integ_ctrl.md
MAC_INTEG_CTRL -- requirements
Module: mac_integ_ctrl

Interface
REQ-001 Parameter DIM_IN, default 16: sample width of a/b lanes (signed).
REQ-002 Parameter DIM_ADD, default 64: accumulator/result width (signed).
REQ-003 Parameter CNT_W, default 24: width of integration-length input and sample counter.
REQ-004 Parameter MAC_LAT, default 3: flush cycles needed for the accumulator pipeline to absorb the last sample.
REQ-005 Ports SHALL be, in order:
- clk  in  1  single system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- n_int  in  CNT_W  samples per integration; 0 treated as 1; sampled only in ACCUM when the counter is 0.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  sample accepted when s_valid&&s_ready.
- s_a, s_b  in  DIM_IN each  signed sample pair.
- mac_en  out  1  accumulator enable.
- mac_clr  out  1  accumulator synchronous clear.
- mac_a, mac_b  out  DIM_IN each  operands to accumulator.
- mac_out  in  DIM_ADD  accumulator result.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream ready.
- m_data  out  DIM_ADD  integrated result.
- ovf  out  1  sticky: result dropped.

Function
REQ-006 FSM states SHALL be ACCUM, FLUSH, CAPTURE.
REQ-007 ACCUM: s_ready=1; mac_en=s_valid; mac_a/mac_b=s_a/s_b; counter increments per accepted sample.
REQ-008 On the accepted sample making count equal max(n_int,1), counter SHALL reset to 0 and next state SHALL be FLUSH.
REQ-009 FLUSH: s_ready=0, mac_en=1, mac_a=mac_b=0, for exactly MAC_LAT cycles, then CAPTURE.
REQ-010 CAPTURE (one cycle): s_ready=0, mac_clr=1, mac_en=0; mac_out SHALL be offered to the output register; next state ACCUM.
REQ-011 Latency: first sample of next integration accepted 2+MAC_LAT cycles after last sample of previous one.
REQ-012 Output register: capture when m_valid=0, or m_valid=1 and m_ready=1 in the same cycle, SHALL load m_data and keep/set m_valid=1.
REQ-013 Capture while m_valid=1 and m_ready=0 SHALL keep old m_data, drop new result, set ovf=1 (sticky until clr).
REQ-014 Handshake m_valid&&m_ready without capture SHALL clear m_valid; m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-015 m_data SHALL be mac_out verbatim, no truncation or rescale.
REQ-016 Outputs mac_a/mac_b/mac_en/mac_clr/s_ready SHALL be combinational from state and inputs; m_valid/m_data/ovf registered.

Reset
REQ-017 clr SHALL force state ACCUM, counter 0, m_valid=0, m_data=0, ovf=0; mac_clr SHALL equal 1 while clr=1.
REQ-018 clr mid-FLUSH or mid-CAPTURE SHALL abandon the integration; no result emitted.

Configuration
REQ-019 MAC_INTEG_FRAME_EN defined: adds output m_frame (32 bit), per-capture counter, wraps 0xFFFFFFFF->0, increments on every CAPTURE (including dropped), loaded alongside m_data, 0 on clr.
REQ-020 MAC_INTEG_FRAME_EN undefined: m_frame port and counter absent; all else identical.

Structure
REQ-021 Package corr_pkg SHALL hold DIM_IN/DIM_ADD/MAC_LAT defaults and the FSM state enum.
REQ-022 Output register/handshake/ovf logic SHALL be sub-module corr_out_reg.

Verification
REQ-023 n_int=4, four samples a=b=2 -> one result m_data=16, ovf=0.
REQ-024 n_int=2, a=b=-32768 twice -> m_data=0x000000007FFFFFFE (saturated-square per sample).
REQ-025 n_int=0, single sample a=3,b=-5 -> m_data=-15; each sample yields one result.
REQ-026 n_int=1, m_ready=0 held, three samples 1*1,2*2,3*3 -> m_data=1 retained, ovf=1; then m_ready=1 -> one handshake, m_valid=0.
REQ-027 clr asserted in 2nd FLUSH cycle, n_int=3 -> no m_valid; next integration a=b=1 x3 -> m_data=3 (no residue).
REQ-028 s_valid toggled 50% with n_int=8, a=1,b=7 -> m_data=56; s_ready low exactly MAC_LAT+1 cycles per integration.
